// File: rtl/frame_buffer_read_arbiter.sv
// Shares the frame-buffer BRAM read port between pattern-finder requesters.
// Round-robin arbitration with bounded locking; returned pixels are routed back by a grant tag.
module frame_buffer_read_arbiter #(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_LOCK     = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [N_REQ-1:0]        req_in,
  input  logic [N_REQ-1:0]        lock_in,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  output logic [N_REQ-1:0]        gnt_out,
  output logic                    rdata_out,
  output logic [N_REQ-1:0]        rvalid_out,
  output logic [ADDR_W-1:0]       bram_addr_out,
  output logic                    bram_en_out,
  input  logic                    bram_data_in
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);
  localparam logic [IdxW:0]      NReqW  = (IdxW + 1)'(N_REQ);
  localparam logic [IdxW-1:0]    LastIdx = IdxW'(N_REQ - 1);
  localparam logic [CntW-1:0]    CntMax = CntW'(MAX_LOCK);
  localparam logic [N_REQ-1:0]   Lsb    = {{(N_REQ - 1){1'b0}}, 1'b1};

  logic [IdxW-1:0]    start_q, start_d;
  logic               lock_valid_q, lock_valid_d;
  logic [IdxW-1:0]    lock_owner_q, lock_owner_d;
  logic [CntW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
  logic               bram_en_q, bram_en_d;
  logic               rdata_q, rdata_d;
  logic [N_REQ-1:0]   tag_q [READ_LATENCY+1];
  logic [N_REQ-1:0]   tag_d [READ_LATENCY+1];

  logic [N_REQ-1:0]   req_eff, req_rr, owner_oh, gnt;
  logic [IdxW-1:0]    gnt_idx;
  logic [IdxW:0]      rr_sum;
  logic               rr_found, lock_expired, lock_ok, others_wait;

  // Grant selection: an unexpired lock wins, otherwise round-robin from start_q.
  always_comb begin
    req_eff      = rst_in ? '0 : req_in;
    owner_oh     = Lsb << lock_owner_q;
    lock_expired = (lock_cnt_q >= CntMax);
    lock_ok      = lock_valid_q && !lock_expired && |(req_eff & owner_oh);
    req_rr       = req_eff;
    // An expired owner sits out one arbitration round if anyone else is waiting.
    if (lock_valid_q && lock_expired && |(req_eff & ~owner_oh)) begin
      req_rr = req_eff & ~owner_oh;
    end
    gnt      = '0;
    gnt_idx  = '0;
    rr_sum   = '0;
    rr_found = 1'b0;
    if (lock_ok) begin
      gnt     = owner_oh;
      gnt_idx = lock_owner_q;
    end else begin
      for (int k = 0; k < int'(N_REQ); k++) begin
        rr_sum = {1'b0, start_q} + (IdxW + 1)'(k);
        if (rr_sum >= NReqW) begin
          rr_sum = rr_sum - NReqW;
        end
        if (!rr_found && req_rr[rr_sum[IdxW-1:0]]) begin
          rr_found = 1'b1;
          gnt_idx  = rr_sum[IdxW-1:0];
        end
      end
      if (rr_found) begin
        gnt = Lsb << gnt_idx;
      end
    end
  end

  always_comb begin
    others_wait = |(req_eff & ~gnt);
    bram_en_d   = |gnt;
    bram_addr_d = bram_addr_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        bram_addr_d = addr_in[i*ADDR_W +: ADDR_W];
      end
    end

    tag_d[0] = gnt;
    for (int k = 1; k <= int'(READ_LATENCY); k++) begin
      tag_d[k] = tag_q[k-1];
    end
    rdata_d = bram_data_in;

    start_d = start_q;
    if (|gnt) begin
      start_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
    end

    lock_valid_d = 1'b0;
    lock_owner_d = '0;
    lock_cnt_d   = '0;
    if (|gnt && lock_in[gnt_idx]) begin
      lock_valid_d = 1'b1;
      lock_owner_d = gnt_idx;
      // Only grants made while someone else waits count towards expiry.
      if (others_wait) begin
        lock_cnt_d = (lock_valid_q && lock_owner_q == gnt_idx) ? lock_cnt_q + 1'b1 : CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      start_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      bram_addr_q  <= '0;
      bram_en_q    <= 1'b0;
      rdata_q      <= 1'b0;
      for (int k = 0; k <= int'(READ_LATENCY); k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      start_q      <= start_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      bram_addr_q  <= bram_addr_d;
      bram_en_q    <= bram_en_d;
      rdata_q      <= rdata_d;
      for (int k = 0; k <= int'(READ_LATENCY); k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign gnt_out       = gnt;
  assign rvalid_out    = tag_q[READ_LATENCY];
  assign rdata_out     = rdata_q;
  assign bram_addr_out = bram_addr_q;
  assign bram_en_out   = bram_en_q;

endmodule
